// File: rtl/phy_tx_pkg.sv
// Shared constants and helpers for the phy_tx lane multiplexer slice.
package phy_tx_pkg;

  localparam int unsigned MODE_TDM     = 0;
  localparam int unsigned MODE_COMPACT = 1;

  localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;

  // Lane index width; a 2-lane mux still needs one index bit.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n <= 2) ? 1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_tdm_nl_if.sv
// Lane-side and stream-side signals of the N:1 TDM lane mux.
interface mux_tdm_nl_if
  import phy_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4
);
  localparam int unsigned LW = lane_w(LANES);

  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   align;
  logic [LANES-1:0]       ready;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [LW-1:0]          lane_out;
  logic                   sof;

  modport master (
    output data_in, valid_in, align,
    input  ready, data_out, valid_out, lane_out, sof
  );

  modport slave (
    input  data_in, valid_in, align,
    output ready, data_out, valid_out, lane_out, sof
  );
endinterface

// File: rtl/rr_arbiter_nl.sv
// Round-robin arbiter: first requesting lane at or after ptr, searched cyclically.
module rr_arbiter_nl
  import phy_tx_pkg::*;
#(
  parameter int unsigned LANES = 4,
  localparam int unsigned LW   = lane_w(LANES)
) (
  input  logic [LANES-1:0] req,
  input  logic [LW-1:0]    ptr,
  output logic [LANES-1:0] grant,
  output logic [LW-1:0]    idx,
  output logic             any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < LANES; k++) begin
      j = (32'(ptr) + k) % LANES;
      if (!any && req[j]) begin
        any      = 1'b1;
        idx      = LW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_tdm_nl.sv
// N-lane to 1 byte-stream multiplexer: fixed-slot TDM or compact round-robin,
// with a registered output stage and combinational per-lane ready.
module mux_tdm_nl
  import phy_tx_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      LANES    = 4,
  parameter int unsigned      MODE     = MODE_TDM,
  parameter int unsigned      IDLE_EN  = 1,
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(IDLE_SYM_DEF)
) (
  input  logic         clk_nf,
  input  logic         reset,
  mux_tdm_nl_if.slave  bus
);

  localparam int unsigned LW = lane_w(LANES);

  logic [LW-1:0]    sel_idx;
  logic             sel_valid;
  logic             upd_lane;
  logic [LANES-1:0] grant_vec;
  logic [WIDTH-1:0] lane_data;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic             sof_q, sof_d;

  if (MODE == MODE_COMPACT) begin : g_compact
    logic [LW-1:0] rr_q, rr_d;
    logic [LANES-1:0] grant;
    logic [LW-1:0]    gidx;
    logic             any;

    rr_arbiter_nl #(.LANES(LANES)) u_arb (
      .req   (bus.valid_in),
      .ptr   (rr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
    );

    // Priority moves past the lane just served; align forces it back to lane 0.
    always_comb begin
      rr_d = rr_q;
      if (any) rr_d = (gidx == LW'(LANES - 1)) ? '0 : gidx + LW'(1);
      if (bus.align) rr_d = '0;
    end

    always_ff @(posedge clk_nf) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
    end

    assign sel_idx   = gidx;
    assign sel_valid = any;
    assign upd_lane  = any;
    assign grant_vec = grant;
  end else begin : g_tdm
    logic [LW-1:0] slot_q, slot_d;

    // Explicit wrap so non-power-of-two lane counts never visit unused slots.
    always_comb begin
      slot_d = (slot_q == LW'(LANES - 1)) ? '0 : slot_q + LW'(1);
      if (bus.align) slot_d = '0;
    end

    always_ff @(posedge clk_nf) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
    end

    assign sel_idx   = slot_q;
    assign sel_valid = bus.valid_in[slot_q];
    assign upd_lane  = 1'b1;
    assign grant_vec = LANES'(1) << slot_q;
  end

  assign lane_data = bus.data_in[32'(sel_idx) * WIDTH +: WIDTH];

  // Output stage next values: idle lanes either insert the idle symbol or hold.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    lane_d  = lane_q;
    sof_d   = sof_q;
    if (sel_valid) begin
      data_d  = lane_data;
      valid_d = 1'b1;
    end else if (IDLE_EN != 0) begin
      data_d  = IDLE_SYM;
    end
    if (upd_lane) begin
      lane_d = sel_idx;
      sof_d  = (sel_idx == '0);
    end
  end

  always_ff @(posedge clk_nf) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      sof_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      sof_q   <= sof_d;
    end
  end

  assign bus.ready     = reset ? '0 : grant_vec;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lane_out  = lane_q;
  assign bus.sof       = sof_q;

endmodule

// File: tb/tb_mux_tdm_nl.sv
// Directed bench for mux_tdm_nl: TDM (idle insert / hold), compact RR, 3-lane wrap.
module tb_mux_tdm_nl;
  import phy_tx_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mux_tdm_nl_if #(.WIDTH(8), .LANES(4)) ifa ();
  mux_tdm_nl_if #(.WIDTH(8), .LANES(4)) ifb ();
  mux_tdm_nl_if #(.WIDTH(8), .LANES(4)) ifc ();
  mux_tdm_nl_if #(.WIDTH(8), .LANES(3)) ifd ();

  mux_tdm_nl #(.WIDTH(8), .LANES(4), .MODE(MODE_TDM), .IDLE_EN(1)) dut_a (
    .clk_nf(clk), .reset(reset), .bus(ifa));
  mux_tdm_nl #(.WIDTH(8), .LANES(4), .MODE(MODE_TDM), .IDLE_EN(0)) dut_b (
    .clk_nf(clk), .reset(reset), .bus(ifb));
  mux_tdm_nl #(.WIDTH(8), .LANES(4), .MODE(MODE_COMPACT), .IDLE_EN(1)) dut_c (
    .clk_nf(clk), .reset(reset), .bus(ifc));
  mux_tdm_nl #(.WIDTH(8), .LANES(3), .MODE(MODE_TDM), .IDLE_EN(1)) dut_d (
    .clk_nf(clk), .reset(reset), .bus(ifd));

  task automatic drive(input logic [31:0] d, input logic [3:0] v, input logic al);
    ifa.data_in = d;        ifa.valid_in = v;      ifa.align = al;
    ifb.data_in = d;        ifb.valid_in = v;      ifb.align = al;
    ifc.data_in = d;        ifc.valid_in = v;      ifc.align = al;
    ifd.data_in = d[23:0];  ifd.valid_in = v[2:0]; ifd.align = al;
  endtask

  // Ends on a negedge with reset just released: next cycle is the first live one.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(32'h44332211, 4'b1111, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ifa.ready !== 4'b0000 || ifc.ready !== 4'b0000) begin
        fails++;
        $display("FAIL reset_ready[%0d] got a=%b c=%b exp 0000", i, ifa.ready, ifc.ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifa.data_out !== 8'h00 || ifa.valid_out !== 1'b0 ||
          ifa.lane_out !== 2'd0 || ifa.sof !== 1'b0) begin
        fails++;
        $display("FAIL reset_out[%0d] got d=%h v=%b l=%0d s=%b exp 00/0/0/0",
                 i, ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.sof);
      end
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic test_tdm_all_valid();
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [3:0] exp_r [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drive(32'h44332211, 4'b1111, 1'b0);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (ifa.ready !== exp_r[i]) begin
        fails++;
        $display("FAIL tdm_ready[%0d] got %b exp %b", i, ifa.ready, exp_r[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifa.data_out !== exp_d[i] || ifa.valid_out !== 1'b1 ||
          ifa.lane_out !== 2'(i % 4) || ifa.sof !== (i % 4 == 0)) begin
        fails++;
        $display("FAIL tdm_out[%0d] got d=%h v=%b l=%0d s=%b exp %h/1/%0d/%b",
                 i, ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.sof,
                 exp_d[i], i % 4, (i % 4 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tdm_idle();
    logic [7:0] exp_a [4] = '{8'h11, 8'h22, 8'hBC, 8'h44};
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h22, 8'h44};
    logic       exp_v [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    drive(32'h44332211, 4'b1011, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ifa.data_out !== exp_a[i] || ifa.valid_out !== exp_v[i] || ifa.lane_out !== 2'(i)) begin
        fails++;
        $display("FAIL idle_ins[%0d] got d=%h v=%b l=%0d exp %h/%b/%0d",
                 i, ifa.data_out, ifa.valid_out, ifa.lane_out, exp_a[i], exp_v[i], i);
      end
      tests_run++;
      if (ifb.data_out !== exp_b[i] || ifb.valid_out !== exp_v[i]) begin
        fails++;
        $display("FAIL idle_hold[%0d] got d=%h v=%b exp %h/%b",
                 i, ifb.data_out, ifb.valid_out, exp_b[i], exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_compact();
    logic [3:0] exp_r [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [7:0] exp_d [4] = '{8'h22, 8'h44, 8'h22, 8'h44};
    logic [1:0] exp_l [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    drive(32'h44332211, 4'b1010, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (ifc.ready !== exp_r[i]) begin
        fails++;
        $display("FAIL rr_ready[%0d] got %b exp %b", i, ifc.ready, exp_r[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifc.data_out !== exp_d[i] || ifc.valid_out !== 1'b1 ||
          ifc.lane_out !== exp_l[i] || ifc.sof !== 1'b0) begin
        fails++;
        $display("FAIL rr_out[%0d] got d=%h v=%b l=%0d s=%b exp %h/1/%0d/0",
                 i, ifc.data_out, ifc.valid_out, ifc.lane_out, ifc.sof, exp_d[i], exp_l[i]);
      end
      @(negedge clk);
    end
    // Grant lane 1 so priority points at lane 2.
    drive(32'h44332211, 4'b0010, 1'b0);
    @(posedge clk); @(negedge clk);
    // No valid lanes but align: idle output, lane holds, priority back to 0.
    drive(32'h44332211, 4'b0000, 1'b1);
    #1;
    tests_run++;
    if (ifc.ready !== 4'b0000) begin
      fails++;
      $display("FAIL rr_noval_ready got %b exp 0000", ifc.ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ifc.data_out !== 8'hBC || ifc.valid_out !== 1'b0 ||
        ifc.lane_out !== 2'd1 || ifc.sof !== 1'b0) begin
      fails++;
      $display("FAIL rr_noval_out got d=%h v=%b l=%0d s=%b exp bc/0/1/0",
               ifc.data_out, ifc.valid_out, ifc.lane_out, ifc.sof);
    end
    @(negedge clk);
    drive(32'h44332211, 4'b1001, 1'b0);
    #1;
    tests_run++;
    if (ifc.ready !== 4'b0001) begin
      fails++;
      $display("FAIL rr_align_ready got %b exp 0001", ifc.ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ifc.data_out !== 8'h11 || ifc.lane_out !== 2'd0 || ifc.sof !== 1'b1) begin
      fails++;
      $display("FAIL rr_align_out got d=%h l=%0d s=%b exp 11/0/1",
               ifc.data_out, ifc.lane_out, ifc.sof);
    end
    @(negedge clk);
  endtask

  task automatic test_align();
    logic [3:0] exp_r [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    drive(32'h44332211, 4'b1111, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      drive(32'h44332211, 4'b1111, (i == 2));
      #1;
      tests_run++;
      if (ifa.ready !== exp_r[i]) begin
        fails++;
        $display("FAIL align_ready[%0d] got %b exp %b", i, ifa.ready, exp_r[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifa.data_out !== exp_d[i]) begin
        fails++;
        $display("FAIL align_out[%0d] got %h exp %h", i, ifa.data_out, exp_d[i]);
      end
      @(negedge clk);
    end
    drive(32'h44332211, 4'b1111, 1'b0);
  endtask

  task automatic test_l3_wrap();
    logic [2:0] exp_r [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
    logic [1:0] exp_l [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    drive(32'h44332211, 4'b1111, 1'b0);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (ifd.ready !== exp_r[i]) begin
        fails++;
        $display("FAIL l3_ready[%0d] got %b exp %b", i, ifd.ready, exp_r[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (ifd.data_out !== exp_d[i] || ifd.lane_out !== exp_l[i]) begin
        fails++;
        $display("FAIL l3_out[%0d] got d=%h l=%0d exp %h/%0d",
                 i, ifd.data_out, ifd.lane_out, exp_d[i], exp_l[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h44332211, 4'b1111, 1'b0);
    do_reset(1);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (ifa.ready !== 4'b0000) begin
      fails++;
      $display("FAIL mid_rst_ready got %b exp 0000", ifa.ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ifa.data_out !== 8'h00 || ifa.valid_out !== 1'b0 ||
        ifa.lane_out !== 2'd0 || ifa.sof !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_out got d=%h v=%b l=%0d s=%b exp 00/0/0/0",
               ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.sof);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (ifa.ready !== 4'b0001) begin
      fails++;
      $display("FAIL mid_rel_ready got %b exp 0001", ifa.ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ifa.data_out !== 8'h11 || ifa.valid_out !== 1'b1 ||
        ifa.lane_out !== 2'd0 || ifa.sof !== 1'b1) begin
      fails++;
      $display("FAIL mid_rel_out got d=%h v=%b l=%0d s=%b exp 11/1/0/1",
               ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.sof);
    end
    @(negedge clk);
  endtask

  initial begin
    drive(32'h0, 4'b0000, 1'b0);
    test_reset();
    test_tdm_all_valid();
    test_tdm_idle();
    test_compact();
    test_align();
    test_l3_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
